seq_match_arbiter: RTL

- Hardware replacement for the testbench's software sequence monitor.
- Two event sources, the fetch/decode stage (ifd) and the execute stage (exec), each present one decoded PDP-8 opcode event per handshake.
- A round-robin arbiter grants one source per cycle into a single shared sequence matcher, which detects a programmable opcode sequence, counts hits and pulses a clear back to both sources.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/seq_match_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types for the opcode sequence matcher: PDP-8 opcode events, source ids
// and the MODE source-enable encodings.
package seq_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NONE, AND, TAD, ISZ, DCA, JMS, JMP, IOT, CLA_CLL, HLT, NOP, OTHER
    } op_t;

    typedef enum logic {
        SRC_IFD  = 1'b0,
        SRC_EXEC = 1'b1
    } src_t;

    localparam int MODE_BOTH = 0;
    localparam int MODE_IFD  = 1;
    localparam int MODE_EXEC = 2;
    localparam int MODE_OFF  = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req[0] is ifd and req[1] is exec; on a tie the
// priority holder wins and priority passes to the other side.
module rr_arb2
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] gnt
);

    src_t prio;
    logic both;

    assign both = req[0] & req[1];

    // Priority moves only when a contested grant is actually issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= SRC_IFD;
        end else if (!hold && both) begin
            prio <= (prio == SRC_IFD) ? SRC_EXEC : SRC_IFD;
        end
    end

    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        if (!hold) begin
            if (both) begin
                gnt = (prio == SRC_IFD) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/seq_match_arbiter.sv
// Arbitrates ifd/exec opcode events into one programmable sequence matcher that
// pulses seq_hit/seq_clear on a completed match and keeps a saturating hit count.
module seq_match_arbiter
    import seq_pkg::*;
#(
    parameter  int MODE    = 0,
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int IDX_W   = $clog2(MAX_LEN),
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ifd_valid,
    input  op_t              ifd_op,
    output logic             ifd_ready,
    input  logic             exec_valid,
    input  op_t              exec_op,
    output logic             exec_ready,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  op_t              cfg_op,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             seq_hit,
    output logic             seq_clear,
    output logic [CNT_W-1:0] hit_count,
    output logic [LEN_W-1:0] match_ptr,
    output logic             last_src
);

    localparam bit BLOCK_ON = (MODE != MODE_OFF);
    localparam bit IFD_EN   = (MODE == MODE_BOTH) || (MODE == MODE_IFD);
    localparam bit EXEC_EN  = (MODE == MODE_BOTH) || (MODE == MODE_EXEC);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             accept;
    op_t              ev_op;
    op_t              seq [MAX_LEN];
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] ptr;
    logic [LEN_W-1:0] ptr_adv;
    logic [LEN_W-1:0] len_clamped;
    logic             hit_now;
    src_t             last_src_q;

    assign req = {exec_valid & EXEC_EN, ifd_valid & IFD_EN};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .hold  (cfg_we),
        .gnt   (gnt)
    );

    // With the block disabled, events are drained and dropped.
    assign ifd_ready  = BLOCK_ON ? gnt[0] : 1'b1;
    assign exec_ready = BLOCK_ON ? gnt[1] : 1'b1;
    assign accept     = |gnt;
    assign ev_op      = gnt[1] ? exec_op : ifd_op;

    // Restart rule: on a miss, only a fresh first-entry match is recognised.
    always_comb begin
        ptr_adv = '0;
        if (len != '0) begin
            if (ev_op == seq[ptr[IDX_W-1:0]]) begin
                ptr_adv = ptr + 1'b1;
            end else if (ev_op == seq[0]) begin
                ptr_adv = LEN_W'(1);
            end
        end
    end

    assign hit_now     = (len != '0) && (ptr_adv == len);
    assign len_clamped = (int'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;

    // NOTE: the sequence table is reset too, since unprogrammed entries must read OP_NONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seq[i] <= OP_NONE;
            end
            len        <= '0;
            ptr        <= '0;
            seq_hit    <= 1'b0;
            seq_clear  <= 1'b0;
            hit_count  <= '0;
            last_src_q <= SRC_IFD;
        end else if (BLOCK_ON) begin
            // NOTE: non-blocking assignments so every read above sees pre-edge state.
            seq_hit   <= 1'b0;
            seq_clear <= 1'b0;
            if (cfg_we) begin
                if (int'(cfg_idx) < MAX_LEN) begin
                    seq[cfg_idx] <= cfg_op;
                end
                len <= len_clamped;
                ptr <= '0;
            end else if (accept) begin
                last_src_q <= gnt[1] ? SRC_EXEC : SRC_IFD;
                if (hit_now) begin
                    ptr       <= '0;
                    seq_hit   <= 1'b1;
                    seq_clear <= 1'b1;
                    if (hit_count != '1) begin
                        hit_count <= hit_count + 1'b1;
                    end
                end else begin
                    ptr <= ptr_adv;
                end
            end
        end
    end

    assign match_ptr = ptr;
    assign last_src  = last_src_q;

endmodule
